// File: rtl/latch_write_sequencer.sv
// latch_write_sequencer
// Shares one level-sensitive data latch between NREQ requesters. Write
// requests are granted round-robin and each write is sequenced as
// SETUP -> OPEN -> HOLD, so lat_d is stable for a full cycle before lat_en
// rises, for the whole time lat_en is high, and for a cycle after it falls.
// A clear request pulses the latch reset and zeroes the shadow copy.
//
// Handshake: req[i] and clr are levels held by the requester until the
// matching one-cycle ack[i] / clr_ack pulse; a requester that still holds
// its request one cycle after that pulse is treated as making a new request.
module latch_write_sequencer #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int EN_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  input  logic                  clr,
  output logic [NREQ-1:0]       ack,
  output logic                  clr_ack,
  output logic [WIDTH-1:0]      lat_d,
  output logic                  lat_en,
  output logic                  lat_rst,
  output logic [WIDTH-1:0]      shadow,
  output logic                  busy,
  output logic [2:0]            dbg_state
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW   = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_OPEN  = 3'd2,
    S_HOLD  = 3'd3,
    S_CLEAR = 3'd4
  } state_t;

  state_t            r_state;
  logic [IDXW-1:0]   r_rr;
  logic [IDXW-1:0]   r_gnt;
  logic [CW-1:0]     r_cnt;

  logic              w_found;
  logic [IDXW-1:0]   w_gnt_idx;
  logic [IDXW:0]     w_sum;
  logic [IDXW-1:0]   w_cand;
  logic [WIDTH-1:0]  w_gnt_data;

  assign dbg_state  = r_state;
  assign w_gnt_data = wdata[int'(w_gnt_idx)*WIDTH +: WIDTH];

  // Round-robin search: first set request at or after the rr pointer, wrapping.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_sum     = '0;
    w_cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, r_rr} + (IDXW+1)'(k);
      if (w_sum >= (IDXW+1)'(NREQ)) begin
        w_sum = w_sum - (IDXW+1)'(NREQ);
      end
      w_cand = w_sum[IDXW-1:0];
      if (!w_found && req[w_cand]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_rr    <= '0;
      r_gnt   <= '0;
      r_cnt   <= '0;
      ack     <= '0;
      clr_ack <= 1'b0;
      lat_d   <= '0;
      lat_en  <= 1'b0;
      lat_rst <= 1'b1;
      shadow  <= '0;
      busy    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          lat_rst <= 1'b0;
          ack     <= '0;
          clr_ack <= 1'b0;
          if (clr) begin
            // Clear wins over any pending write request.
            r_state <= S_CLEAR;
            lat_rst <= 1'b1;
            clr_ack <= 1'b1;
            shadow  <= '0;
            busy    <= 1'b1;
          end else if (w_found) begin
            // Data is captured here and held until the next grant.
            r_gnt   <= w_gnt_idx;
            lat_d   <= w_gnt_data;
            busy    <= 1'b1;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          lat_en  <= 1'b1;
          r_cnt   <= CW'(EN_CYCLES - 1);
          r_state <= S_OPEN;
        end
        S_OPEN: begin
          if (r_cnt == '0) begin
            lat_en  <= 1'b0;
            ack     <= NREQ'(1) << r_gnt;
            shadow  <= lat_d;
            r_state <= S_HOLD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_HOLD: begin
          ack     <= '0;
          r_rr    <= (r_gnt == IDXW'(NREQ - 1)) ? '0 : r_gnt + 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        S_CLEAR: begin
          lat_rst <= 1'b0;
          clr_ack <= 1'b0;
          shadow  <= '0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/latch_write_sequencer.md
# latch_write_sequencer

Controller that shares one 8-bit level-sensitive data latch (ports d, clk, q, rst) between several requesters. It arbitrates write requests round-robin and sequences each write as setup, open and hold phases, so latch data is never changing while the latch enable is high. It also serves a clear request through the latch reset and keeps a shadow copy of the latched value. It sits between the requesting blocks and the latch instance.

## Interface
- NREQ, 4: number of requesters, 2..8
- WIDTH, 8: data width; matches the latch
- EN_CYCLES, 1: cycles lat_en stays high per write, 1..15

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester write request; level, held until matching ack
- wdata  in  NREQ*WIDTH  requester i data at bits [i*WIDTH +: WIDTH]
- clr  in  1  clear request; level, held until clr_ack
- ack  out  NREQ  one-cycle write-done pulse, one-hot
- clr_ack  out  1  one-cycle clear-done pulse
- lat_d  out  WIDTH  drives latch d
- lat_en  out  1  drives latch clk (transparent when 1)
- lat_rst  out  1  drives latch rst (active-high clear)
- shadow  out  WIDTH  last value written to the latch; 0 after clear or reset
- busy  out  1  1 whenever state is not IDLE

## Operation
- All outputs registered. Reset values: ack=0, clr_ack=0, lat_d=0, lat_en=0, lat_rst=1, shadow=0, busy=0, state=IDLE, rr pointer=0.
- States: IDLE, SETUP, OPEN, HOLD, CLEAR.
- IDLE:
  - clr=1 -> CLEAR. clr has priority over any req.
  - Otherwise, any req -> grant the first set req at or after the rr pointer, wrapping modulo NREQ.
  - On grant, lat_d <= wdata of the granted requester, latch the grant index, go to SETUP.
  - lat_rst <= 0 on every IDLE cycle.
- SETUP: one cycle, lat_en=0, lat_d stable -> OPEN, lat_en <= 1, load the enable counter.
- OPEN: lat_en held 1 for EN_CYCLES cycles. On expiry, lat_en <= 0, ack[g] <= 1, shadow <= lat_d -> HOLD.
- HOLD: one cycle, lat_d still stable. ack <= 0, rr pointer <= (g+1) mod NREQ -> IDLE.
- CLEAR: lat_rst <= 1 for one cycle, shadow <= 0, clr_ack pulses 1 -> IDLE (lat_rst returns to 0).
- lat_d changes only on the grant edge. It never changes while lat_en=1 or in the cycle after lat_en falls.
- Data is captured at grant. If req or wdata change after grant, the transaction still completes with the captured data.
- If req[g] drops before ack, ack[g] still pulses.
- clr asserted during a write waits; it is served in the next IDLE cycle, ahead of pending reqs.
- If rst asserts mid-operation, all registers take their reset values immediately: lat_en=0, lat_rst=1, and no ack or clr_ack is issued. The interrupted write is lost.

## Timing
- Write latency (EN_CYCLES=E):
  - Grant edge G.
  - lat_en high from G+1 to G+1+E.
  - ack high in cycle G+1+E .. G+2+E.
  - IDLE again at edge G+2+E.
  - The next grant is possible at edge G+3+E.
- Back-to-back writes (E=1) cost 4 cycles each.
- Clear latency: CLEAR entered at edge C, lat_rst and clr_ack high for cycle C+1, IDLE at C+1.
- A requester must drop req within one cycle of seeing ack; otherwise it is re-arbitrated as a new write.

## Test plan
- Reset release, no requests -> lat_rst=1 until the first clk edge, then 0; lat_en=0, shadow=0, busy=0.
- req[2]=1, wdata[2]=0xA5, E=1 -> lat_d=0xA5 at grant, lat_en high for exactly 1 cycle, lat_d stable one cycle before and after, ack=0b0100 once, shadow=0xA5.
- req=0b1111 held continuously with data 0x11,0x22,0x33,0x44 -> ack order 0,1,2,3,0; shadow follows 0x11,0x22,0x33,0x44; grants 4 cycles apart.
- clr and req[0] (0x6D) asserted in the same cycle while idle -> clear first (clr_ack, shadow=0), then write 0x6D.
- E=3, req[1]=0xC5; wdata[1] changed to 0x80 during OPEN -> lat_en high 3 cycles, lat_d stays 0xC5, shadow=0xC5.
- rst pulsed low during OPEN -> lat_en drops immediately, lat_rst=1, no ack; after release a held req[1] is re-granted and completes normally.
